// File: rtl/ps2_pkg.sv
// Shared types, command bytes and helpers for the PS/2 host-side blocks.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2tx_state_t;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

  // Whole clock cycles in a time span; truncating division keeps the spans conservative.
  function automatic int unsigned us_to_cycles(input int unsigned clkfreq_khz,
                                               input int unsigned us);
    return (clkfreq_khz * us) / 32'd1000;
  endfunction

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronises the raw PS/2 clock and data lines into the core clock domain
// and flags the falling edge of the synchronised clock line.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic clkps2_in,
  input  logic dataps2_in,
  output logic clkps2_sync,
  output logic dataps2_sync,
  output logic fall
);

  logic clk_meta_r;
  logic clk_sync_r;
  logic clk_prev_r;
  logic data_meta_r;
  logic data_sync_r;

  // Two-flop synchronisers; idle lines are high so reset to 1 to avoid a phantom edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= clkps2_in;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= dataps2_in;
      data_sync_r <= data_meta_r;
    end
  end

  assign clkps2_sync  = clk_sync_r;
  assign dataps2_sync = data_sync_r;
  assign fall         = clk_prev_r & ~clk_sync_r;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// shifts out one command byte on device clock edges and checks the ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLKFREQ       = 6667,
  parameter int unsigned INHIBIT_US    = 100,
  parameter int unsigned TOUT_FIRST_US = 15000,
  parameter int unsigned TOUT_PKT_US   = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clkps2_in,
  input  logic       dataps2_in,
  output logic       clkps2_oe,
  output logic       dataps2_oe,
  input  logic [7:0] din,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned INHIBIT_CYC = us_to_cycles(CLKFREQ, INHIBIT_US);
  localparam int unsigned FIRST_CYC   = us_to_cycles(CLKFREQ, TOUT_FIRST_US);
  localparam int unsigned PKT_CYC     = us_to_cycles(CLKFREQ, TOUT_PKT_US);
  localparam int unsigned MAX_A       = (FIRST_CYC > PKT_CYC) ? FIRST_CYC : PKT_CYC;
  localparam int unsigned MAX_CYC     = (MAX_A > INHIBIT_CYC) ? MAX_A : INHIBIT_CYC;
  localparam int          CNT_W       = (MAX_CYC > 32'd1) ? $clog2(MAX_CYC) : 1;

  // Counters are loaded with N-1 and expire on the cycle they are seen at zero,
  // so an expiry lands exactly N cycles after the load.
  localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYC - 32'd1);
  localparam logic [CNT_W-1:0] FIRST_LOAD   = CNT_W'(FIRST_CYC - 32'd1);
  localparam logic [CNT_W-1:0] PKT_LOAD     = CNT_W'(PKT_CYC - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  ps2tx_state_t     state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic [9:0]       shreg_r, shreg_nx_s;
  logic [3:0]       bitcnt_r, bitcnt_nx_s;
  logic             clk_oe_r, clk_oe_nx_s;
  logic             data_oe_r, data_oe_nx_s;
  logic             busy_r, busy_nx_s;
  logic             done_r, done_nx_s;
  logic             error_r, error_nx_s;

  logic             clk_sync_s;
  logic             data_sync_s;
  logic             fall_s;
  logic             expired_s;

  ps2_line_sync u_sync (
    .clk          (clk),
    .reset        (reset),
    .clkps2_in    (clkps2_in),
    .dataps2_in   (dataps2_in),
    .clkps2_sync  (clk_sync_s),
    .dataps2_sync (data_sync_s),
    .fall         (fall_s)
  );

  assign expired_s = (cnt_r == CNT_ZERO);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; a watchdog expiry takes priority over a coincident clock edge.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (send) state_nx_s = ST_INHIBIT;
        else      state_nx_s = ST_IDLE;
      end
      ST_INHIBIT: begin
        if (expired_s) state_nx_s = ST_RTS;
        else           state_nx_s = ST_INHIBIT;
      end
      ST_RTS: begin
        if (expired_s) state_nx_s = ST_IDLE;
        else           state_nx_s = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (expired_s)                        state_nx_s = ST_IDLE;
        else if (fall_s && bitcnt_r == 4'd9)  state_nx_s = ST_ACK;
        else                                  state_nx_s = ST_SHIFT;
      end
      ST_ACK: begin
        if (expired_s)                  state_nx_s = ST_IDLE;
        else if (fall_s && !data_sync_s) state_nx_s = ST_WAIT_IDLE;
        else if (fall_s)                 state_nx_s = ST_IDLE;
        else                             state_nx_s = ST_ACK;
      end
      ST_WAIT_IDLE: begin
        if (expired_s)                      state_nx_s = ST_IDLE;
        else if (clk_sync_s && data_sync_s) state_nx_s = ST_IDLE;
        else                                state_nx_s = ST_WAIT_IDLE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Next values of line drivers, status pulses, watchdog and shifter.
  always_comb begin
    cnt_nx_s     = cnt_r;
    shreg_nx_s   = shreg_r;
    bitcnt_nx_s  = bitcnt_r;
    clk_oe_nx_s  = clk_oe_r;
    data_oe_nx_s = data_oe_r;
    busy_nx_s    = busy_r;
    done_nx_s    = 1'b0;
    error_nx_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (send) begin
          shreg_nx_s   = {1'b1, odd_parity(din), din};
          cnt_nx_s     = INHIBIT_LOAD;
          clk_oe_nx_s  = 1'b1;
          data_oe_nx_s = 1'b0;
          busy_nx_s    = 1'b1;
        end else begin
          clk_oe_nx_s  = 1'b0;
          data_oe_nx_s = 1'b0;
          busy_nx_s    = 1'b0;
        end
      end
      ST_INHIBIT: begin
        if (expired_s) begin
          data_oe_nx_s = 1'b1;
          cnt_nx_s     = FIRST_LOAD;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      ST_RTS: begin
        if (expired_s) begin
          clk_oe_nx_s  = 1'b0;
          data_oe_nx_s = 1'b0;
          busy_nx_s    = 1'b0;
          error_nx_s   = 1'b1;
        end else begin
          clk_oe_nx_s = 1'b0;
          cnt_nx_s    = FIRST_LOAD;
          bitcnt_nx_s = 4'd0;
        end
      end
      ST_SHIFT: begin
        if (expired_s) begin
          clk_oe_nx_s  = 1'b0;
          data_oe_nx_s = 1'b0;
          busy_nx_s    = 1'b0;
          error_nx_s   = 1'b1;
        end else if (fall_s) begin
          data_oe_nx_s = ~shreg_r[0];
          shreg_nx_s   = {1'b0, shreg_r[9:1]};
          bitcnt_nx_s  = bitcnt_r + 4'd1;
          // Once the device has started clocking, the whole packet gets a shorter budget.
          if (bitcnt_r == 4'd0) cnt_nx_s = PKT_LOAD;
          else                  cnt_nx_s = cnt_r - CNT_ONE;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      ST_ACK: begin
        if (expired_s || (fall_s && data_sync_s)) begin
          clk_oe_nx_s  = 1'b0;
          data_oe_nx_s = 1'b0;
          busy_nx_s    = 1'b0;
          error_nx_s   = 1'b1;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      ST_WAIT_IDLE: begin
        if (expired_s) begin
          clk_oe_nx_s  = 1'b0;
          data_oe_nx_s = 1'b0;
          busy_nx_s    = 1'b0;
          error_nx_s   = 1'b1;
        end else if (clk_sync_s && data_sync_s) begin
          clk_oe_nx_s  = 1'b0;
          data_oe_nx_s = 1'b0;
          busy_nx_s    = 1'b0;
          done_nx_s    = 1'b1;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        clk_oe_nx_s  = 1'b0;
        data_oe_nx_s = 1'b0;
        busy_nx_s    = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset releases both lines at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= CNT_ZERO;
      shreg_r   <= 10'd0;
      bitcnt_r  <= 4'd0;
      clk_oe_r  <= 1'b0;
      data_oe_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      cnt_r     <= cnt_nx_s;
      shreg_r   <= shreg_nx_s;
      bitcnt_r  <= bitcnt_nx_s;
      clk_oe_r  <= clk_oe_nx_s;
      data_oe_r <= data_oe_nx_s;
      busy_r    <= busy_nx_s;
      done_r    <= done_nx_s;
      error_r   <= error_nx_s;
    end
  end

  assign clkps2_oe  = clk_oe_r;
  assign dataps2_oe = data_oe_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-collector device model clocks frames out of
// the host, decodes them and a scoreboard compares against the bytes sent.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned CLKFREQ       = 6667;
  localparam int unsigned INHIBIT_US    = 100;
  // First-edge timeout shortened to keep the run brief: 6667*1500/1000 = 10000.
  localparam int unsigned TOUT_FIRST_US = 1500;
  localparam int unsigned TOUT_PKT_US   = 2000;
  localparam int EXP_INHIBIT = 666;     // 6667*100/1000
  localparam int EXP_FIRST   = 10000;   // 6667*1500/1000
  localparam int EXP_PKT     = 13334;   // 6667*2000/1000
  // Raw fall -> two sync stages -> cycle that consumes fall and reloads the watchdog.
  localparam int FALL_LAT    = 3;
  localparam int HALF        = 267;     // 40 us device clock half-period in core cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       clkps2_oe, dataps2_oe, busy, done, error;
  logic       clk_line, data_line;

  assign clk_line  = ~(clkps2_oe | dev_clk_low);
  assign data_line = ~(dataps2_oe | dev_data_low);

  ps2_host_tx #(
    .CLKFREQ(CLKFREQ), .INHIBIT_US(INHIBIT_US),
    .TOUT_FIRST_US(TOUT_FIRST_US), .TOUT_PKT_US(TOUT_PKT_US)
  ) dut (
    .clk(clk), .reset(reset), .clkps2_in(clk_line), .dataps2_in(data_line),
    .clkps2_oe(clkps2_oe), .dataps2_oe(dataps2_oe), .din(din), .send(send),
    .busy(busy), .done(done), .error(error)
  );

  always #75 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0;
  int rel_cyc = 0, err_cyc = 0, first_fall_cyc = 0;
  logic prev_clk_oe = 1'b0;
  logic lat_a = 1'b0, lat_b = 1'b0;
  logic [7:0] exp_q[$];

  // Free-running cycle index.
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor sampled on the falling edge, away from output updates.
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (error) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (done && error) both_cnt <= both_cnt + 1;
    if (clkps2_oe && !dataps2_oe && busy) inh_cnt <= inh_cnt + 1;
    if (prev_clk_oe && !clkps2_oe) rel_cyc <= cyc;
    prev_clk_oe <= clkps2_oe;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #10;
    din  = b;
    send = 1'b1;
    @(posedge clk); #1;
    check("busy_rise", 32'(busy), 32'd1);
    #9;
    send = 1'b0;
  endtask

  // Device side: wait for request-to-send, then generate nclk clock pulses.
  // bits[0] = start, bits[1..10] = data/parity/stop sampled on rising edges, bits[11] = ack level.
  task automatic dev_transfer(input int nclk, input bit do_ack, output logic [11:0] bits);
    bit found;
    found = 1'b0;
    bits  = 12'd0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (busy && !clkps2_oe && dataps2_oe) begin
        found = 1'b1;
        break;
      end
    end
    check("rts_seen", 32'(found), 32'd1);
    if (found) begin
      repeat (30) @(posedge clk);
      #10;
      bits[0] = data_line;
      for (int i = 1; i <= nclk; i++) begin
        if (i == 11 && do_ack) begin
          dev_data_low = 1'b1;
          repeat (20) @(posedge clk);
          #10;
        end
        dev_clk_low = 1'b1;
        if (i == 1) begin
          first_fall_cyc = cyc;
          repeat (2) @(posedge clk);
          #1 lat_a = dataps2_oe;
          @(posedge clk);
          #1 lat_b = dataps2_oe;
          repeat (HALF - 3) @(posedge clk);
          #10;
        end else begin
          repeat (HALF) @(posedge clk);
          #10;
        end
        dev_clk_low = 1'b0;
        bits[i] = data_line;
        repeat (HALF) @(posedge clk);
        #10;
        if (i == 11) dev_data_low = 1'b0;
      end
    end
  endtask

  task automatic sb_check(input logic [11:0] bits);
    logic [7:0] exp;
    check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check("start_bit", 32'(bits[0]), 32'd0);
      check("sb_byte", 32'(bits[8:1]), 32'(exp));
      check("parity_odd", 32'(^bits[9:1]), 32'd1);
      check("stop_bit", 32'(bits[10]), 32'd1);
    end
  endtask

  task automatic wait_err(input int base, input int limit, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk); #1;
      if (err_cnt != base) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Hard stop in case something stalls beyond every bounded wait.
  initial begin
    #(64'd150 * 64'd90000);
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "bench stalled");
  end

  initial begin
    logic [11:0] bits;
    int d0, e0, i0;
    bit seen;

    repeat (5) @(posedge clk);
    #10 reset = 1'b0;
    @(posedge clk); #1;
    check("reset_outs", 32'({clkps2_oe, dataps2_oe, busy, done, error}), 32'd0);

    // 0xED against an ACKing device.
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
    exp_q.push_back(PS2_CMD_LEDS);
    send_byte(PS2_CMD_LEDS);
    dev_transfer(11, 1'b1, bits);
    repeat (20) @(posedge clk);
    #1;
    check("inhibit_cycles", 32'(inh_cnt - i0), 32'(EXP_INHIBIT));
    check("start_held_2cyc", 32'(lat_a), 32'd1);
    check("d0_out_3cyc", 32'(lat_b), 32'd0);
    sb_check(bits);
    check("ed_parity", 32'(bits[9]), 32'd1);
    check("ed_done", 32'(done_cnt - d0), 32'd1);
    check("ed_no_err", 32'(err_cnt - e0), 32'd0);
    check("ed_busy", 32'(busy), 32'd0);

    // 0xF4: parity bit must be 0.
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(PS2_CMD_ENABLE);
    send_byte(PS2_CMD_ENABLE);
    dev_transfer(11, 1'b1, bits);
    repeat (20) @(posedge clk);
    #1;
    sb_check(bits);
    check("f4_parity", 32'(bits[9]), 32'd0);
    check("f4_done", 32'(done_cnt - d0), 32'd1);
    check("f4_no_err", 32'(err_cnt - e0), 32'd0);

    // Device withholds the ACK.
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(8'h3C);
    send_byte(8'h3C);
    dev_transfer(11, 1'b0, bits);
    repeat (5) @(posedge clk);
    #1;
    sb_check(bits);
    check("nack_err", 32'(err_cnt - e0), 32'd1);
    check("nack_no_done", 32'(done_cnt - d0), 32'd0);
    check("nack_oe", 32'({clkps2_oe, dataps2_oe}), 32'd0);
    check("nack_busy", 32'(busy), 32'd0);

    // Device never clocks: first-edge watchdog.
    e0 = err_cnt;
    send_byte(PS2_CMD_ENABLE);
    wait_err(e0, EXP_FIRST + 2000, seen);
    check("first_tout_seen", 32'(seen), 32'd1);
    check("first_tout_cycles", 32'(err_cyc - rel_cyc), 32'(EXP_FIRST));
    check("first_tout_oe", 32'({clkps2_oe, dataps2_oe}), 32'd0);
    check("first_tout_busy", 32'(busy), 32'd0);

    // Device stops after 4 bits: packet watchdog.
    e0 = err_cnt;
    send_byte(8'h5A);
    dev_transfer(4, 1'b1, bits);
    wait_err(e0, EXP_PKT + 2000, seen);
    check("pkt_tout_seen", 32'(seen), 32'd1);
    check("pkt_tout_cycles", 32'(err_cyc - first_fall_cyc), 32'(EXP_PKT + FALL_LAT));
    check("pkt_tout_oe", 32'({clkps2_oe, dataps2_oe}), 32'd0);

    // Asynchronous reset after bit 5 (0xE5 has d4 = 0, so data is pulled).
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hE5);
    dev_transfer(5, 1'b1, bits);
    check("pre_rst_data_oe", 32'(dataps2_oe), 32'd1);
    #20 reset = 1'b1;
    #1;
    check("rst_oe", 32'({clkps2_oe, dataps2_oe}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #10 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_no_err", 32'(err_cnt - e0), 32'd0);

    // 0xFF with stray send pulses while busy.
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(PS2_CMD_RESET);
    send_byte(PS2_CMD_RESET);
    fork
      dev_transfer(11, 1'b1, bits);
      begin
        for (int p = 0; p < 3; p++) begin
          repeat (1500) @(posedge clk);
          #10;
          din  = 8'h00;
          send = 1'b1;
          @(posedge clk);
          #10 send = 1'b0;
        end
      end
    join
    repeat (50) @(posedge clk);
    #1;
    sb_check(bits);
    check("ff_done_once", 32'(done_cnt - d0), 32'd1);
    check("ff_no_err", 32'(err_cnt - e0), 32'd0);
    check("ff_idle_after", 32'(busy), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("done_err_excl", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter, the outbound counterpart of the PS/2 keyboard receiver in the Jupiter Ace cores. It drives the open-collector clkps2/dataps2 lines to send one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable). It sits beside the keyboard block in the top level, clocked from the core clock, and the top level builds the tri-states from its `*_oe` outputs. While `busy` is high the receiver ignores line activity.

## Interface
- `CLKFREQ`, default 6667: core clock frequency in kHz.
- `INHIBIT_US`, default 100: time clkps2 is held low before the request-to-send.
- `TOUT_FIRST_US`, default 15000: maximum wait for the device's first clock falling edge.
- `TOUT_PKT_US`, default 2000: maximum time from the first falling edge to the ACK.
- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-high.
- `clkps2_in` in 1: raw clkps2 line level.
- `dataps2_in` in 1: raw dataps2 line level.
- `clkps2_oe` out 1: 1 pulls clkps2 low, 0 releases it.
- `dataps2_oe` out 1: 1 pulls dataps2 low, 0 releases it.
- `din` in 8: byte to send.
- `send` in 1: start request, sampled only in IDLE.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse when the device acknowledged.
- `error` out 1: one-cycle pulse on NACK or timeout.

## Operation
- Inputs pass through a 2-FF synchronizer. `fall` is asserted for one cycle when the synchronized clkps2 goes from 1 to 0.
- Cycle counts use integer division: N = CLKFREQ*US/1000. At the defaults: inhibit = 666, first-edge timeout = 100005, packet timeout = 13334. The counter width is $clog2 of the largest count.
- Shift register is 10 bits, {1'b1 stop, parity, din}, sent LSB first. Parity is odd: parity = ~^din.
- States:
  - IDLE: `send`=1 latches `din`, loads the shift register and the inhibit count, and sets `busy`=1 and `clkps2_oe`=1. Go to INHIBIT.
  - INHIBIT: count down to 0, then set `dataps2_oe`=1 (start bit). Go to RTS.
  - RTS: one cycle with both lines pulled. Then `clkps2_oe`=0, load the watchdog with the first-edge timeout, bit count = 0. Go to SHIFT.
  - SHIFT: on each `fall`, `dataps2_oe` = ~shreg[0], shift right, bitcnt+1. The first `fall` reloads the watchdog with the packet timeout. Once bitcnt reaches 10 the stop bit has released dataps2. Go to ACK.
  - ACK: on `fall`, sample synchronized dataps2. 0 means go to WAIT_IDLE. 1 means NACK: pulse `error` and go to IDLE.
  - WAIT_IDLE: when synchronized clkps2 and dataps2 are both 1, pulse `done` and go to IDLE.
- Watchdog expiry in RTS, SHIFT, ACK or WAIT_IDLE: release both lines, pulse `error`, go to IDLE.
- On every transition to IDLE: both `_oe` = 0 and `busy` = 0.

## Timing
- Reset values: `clkps2_oe`=0, `dataps2_oe`=0, `busy`=0, `done`=0, `error`=0, state IDLE.
- An asynchronous reset mid-transfer releases both lines immediately. The transfer is abandoned with no `done` and no `error`.
- `busy` rises the cycle after `send` is sampled and falls in the same cycle as `done` or `error`.
- `send` while busy is ignored; there is no queueing. `send` held high through completion starts a new transfer the cycle after `busy` falls.
- Data output changes 2–3 `clk` cycles after the raw clkps2 falling edge, well inside the device's clock-low half-period of at least 30 µs.
- `done` and `error` are never asserted together.
- A `fall` in the same cycle as watchdog expiry: the timeout wins.

## Structure
- Package `ps2_pkg`:
  - state enum `ps2tx_state_t`;
  - command constants `PS2_CMD_RESET`=0xFF, `PS2_CMD_LEDS`=0xED, `PS2_CMD_ENABLE`=0xF4;
  - a function converting µs to cycles.
- Sub-module `ps2_line_sync`: 2-FF synchronizer for both lines plus the clkps2 falling-edge detector. The keyboard receiver reuses it.

## Test plan
- Send 0xED against a device model with a 40 µs clock half-period. Required: `clkps2_oe` held for 666 cycles, then start bit 0. Data sequence on successive falls: 1,0,1,1,0,1,1,1, parity 1, stop released. Model ACKs, then `done` pulses exactly once and `busy` = 0.
- Send 0xF4. Required: parity bit 0; model decodes 0xF4 with no parity error.
- Model drives no ACK (dataps2 high on the 11th fall). Required: `error` pulse, both `_oe` = 0.
- Model never clocks. Required: `error` exactly 100005 cycles after clkps2 is released.
- Model stops clocking after 4 bits. Required: `error` 13334 cycles after the first fall.
- Assert `reset` in SHIFT at bit 5. Required: both `_oe` = 0 combinationally. A second `send` of 0xFF afterwards completes with `done`. `send` pulses while busy are ignored, giving exactly one `done` per accepted `send`.
